// File: rtl/asi_rmem_pkg.sv
// asi_pkg: shared AXI slave burst constants and byte-lane helper
package asi_pkg;

    localparam logic [1:0] BT_FIXED = 2'b00;
    localparam logic [1:0] BT_INCR  = 2'b01;
    localparam logic [1:0] BT_WRAP  = 2'b10;

    localparam int MAX_BYTES = 128;

    // Active lanes of a beat: size-aligned start, 2**size bytes wide
    function automatic logic [MAX_BYTES-1:0] lane_mask(input logic [6:0] addr_lo, input logic [2:0] size);
        logic [7:0] n;
        logic [7:0] lo;
        n = 8'd1 << size;
        lo = {1'b0, addr_lo} & ~(n - 8'd1);
        lane_mask = '0;
        for (int i = 0; i < MAX_BYTES; i++) lane_mask[i] = (8'(i) >= lo) && (8'(i) < lo + n);
    endfunction

endpackage

// File: rtl/asi_rmem_sat_cnt.sv
// asi_sat_cnt: saturating up-counter with synchronous clear
module asi_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk)
        if (!rst_n || clr) cnt <= '0;
        else if (inc && cnt != '1) cnt <= cnt + 1'b1;

endmodule

// File: rtl/asi_rmem.sv
// asi_rmem: SRAM read adapter for the AXI slave read path, fixed SLV_WS latency,
// range check, byte-lane masking and saturating traffic counters.
module asi_rmem
    import asi_pkg::*;
#(
    parameter int                AXI_DW    = 128,
    parameter int                AXI_AW    = 40,
    parameter int                AXI_SW    = 3,
    parameter int                SLV_WS    = 2,
    parameter int                MEM_AW    = 10,
    parameter logic [AXI_AW-1:0] BASE_ADDR = '0,
    parameter int                CNT_W     = 32
) (
    input  logic              usr_clk,
    input  logic              usr_reset_n,
    input  logic [AXI_AW-1:0] m_raddr,
    input  logic              m_re,
    input  logic [AXI_SW-1:0] m_rsize,
    input  logic              m_rlast,
    output logic [AXI_DW-1:0] m_rdata,
    output logic              m_rvalid,
    output logic              m_rslverr,
    output logic              mem_ce,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [AXI_DW-1:0] mem_rdata,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_beats,
    output logic [CNT_W-1:0]  cnt_bursts,
    output logic [CNT_W-1:0]  cnt_errs
);

    localparam int SLV_BYTES = AXI_DW / 8;
    localparam int LANE_W    = $clog2(SLV_BYTES);
    localparam logic [AXI_AW:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [AXI_AW:0] WIN_HI = WIN_LO + ((AXI_AW + 1)'(SLV_BYTES) << MEM_AW);

    typedef struct packed {
        logic              v;
        logic              e;
        logic              l;
        logic [AXI_DW-1:0] d;
    } beat_t;

    if (SLV_WS < 1) begin : g_bad_ws
        $fatal(1, "asi_rmem: SLV_WS must be >= 1");
    end

    logic                 err;
    logic [AXI_AW-1:0]    off;
    logic [SLV_BYTES-1:0] mask;
    logic                 s1_v, s1_e, s1_l;
    logic [SLV_BYTES-1:0] s1_mask;
    logic [AXI_DW-1:0]    bmask;
    beat_t                st [SLV_WS];
    beat_t                out;

    // Compare one bit wider than the address so the window end cannot overflow
    assign err      = (m_rsize > AXI_SW'(LANE_W)) || ({1'b0, m_raddr} < WIN_LO) || ({1'b0, m_raddr} >= WIN_HI);
    assign off      = m_raddr - BASE_ADDR;
    assign mem_ce   = m_re & ~err;
    assign mem_addr = MEM_AW'(off >> LANE_W);
    assign mask     = err ? '0 : SLV_BYTES'(lane_mask(7'(m_raddr[LANE_W-1:0]), 3'(m_rsize)));

    always_ff @(posedge usr_clk)
        if (!usr_reset_n) begin
            s1_v    <= 1'b0;
            s1_e    <= 1'b0;
            s1_l    <= 1'b0;
            s1_mask <= '0;
        end else begin
            s1_v    <= m_re;
            s1_e    <= m_re & err;
            s1_l    <= m_re & m_rlast;
            s1_mask <= mask;
        end

    always_comb begin
        bmask = '0;
        for (int b = 0; b < SLV_BYTES; b++) bmask[b*8 +: 8] = {8{s1_mask[b]}};
    end

    assign st[0] = {s1_v, s1_e, s1_l, mem_rdata & bmask};

    for (genvar k = 1; k < SLV_WS; k++) begin : g_dly
        beat_t r;
        always_ff @(posedge usr_clk) r <= usr_reset_n ? st[k-1] : '0;
        assign st[k] = r;
    end

    assign out       = st[SLV_WS-1];
    assign m_rvalid  = out.v;
    assign m_rslverr = out.e;
    assign m_rdata   = out.v ? out.d : '0;

    asi_sat_cnt #(.CNT_W(CNT_W)) u_cnt_beats (
        .clk(usr_clk), .rst_n(usr_reset_n), .clr(cnt_clr), .inc(out.v), .cnt(cnt_beats)
    );
    asi_sat_cnt #(.CNT_W(CNT_W)) u_cnt_bursts (
        .clk(usr_clk), .rst_n(usr_reset_n), .clr(cnt_clr), .inc(out.v & out.l), .cnt(cnt_bursts)
    );
    asi_sat_cnt #(.CNT_W(CNT_W)) u_cnt_errs (
        .clk(usr_clk), .rst_n(usr_reset_n), .clr(cnt_clr), .inc(out.v & out.e), .cnt(cnt_errs)
    );

endmodule

// File: tb/tb_asi_rmem.sv
// tb_asi_rmem: directed vector bench for asi_rmem with a registered SRAM model
module tb_asi_rmem;

    localparam int DW  = 128;
    localparam int AW  = 40;
    localparam int SW  = 3;
    localparam int WS  = 2;
    localparam int MAW = 4;
    localparam int CW  = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [AW-1:0]  raddr;
    logic           re;
    logic [SW-1:0]  rsize;
    logic           rlast;
    logic [DW-1:0]  rdata;
    logic           rvalid;
    logic           rslverr;
    logic           ce;
    logic [MAW-1:0] maddr;
    logic [DW-1:0]  mrdata;
    logic           clr;
    logic [CW-1:0]  beats, bursts, errs;

    logic [DW-1:0] mem [16];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (ce) mrdata <= mem[maddr];

    asi_rmem #(
        .AXI_DW(DW), .AXI_AW(AW), .AXI_SW(SW), .SLV_WS(WS), .MEM_AW(MAW),
        .BASE_ADDR(40'h1000), .CNT_W(CW)
    ) dut (
        .usr_clk(clk), .usr_reset_n(rst_n), .m_raddr(raddr), .m_re(re), .m_rsize(rsize),
        .m_rlast(rlast), .m_rdata(rdata), .m_rvalid(rvalid), .m_rslverr(rslverr),
        .mem_ce(ce), .mem_addr(maddr), .mem_rdata(mrdata), .cnt_clr(clr),
        .cnt_beats(beats), .cnt_bursts(bursts), .cnt_errs(errs)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [2:0]    size;
        logic          last;
        logic          ce;
        logic [3:0]    maddr;
        logic          err;
        int            lo;
        int            n;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_data(input int w, input int lo, input int n);
        logic [DW-1:0] d;
        d = '0;
        for (int b = lo; b < lo + n; b++) d[b*8 +: 8] = mem[w][b*8 +: 8];
        return d;
    endfunction

    task automatic drive(input logic [AW-1:0] a, input logic [2:0] s, input logic l, input logic r);
        raddr = a;
        rsize = s;
        rlast = l;
        re    = r;
    endtask

    initial begin
        for (int w = 0; w < 16; w++)
            for (int b = 0; b < 16; b++) mem[w][b*8 +: 8] = 8'(w * 16 + b) ^ 8'h5A;

        vt[0] = '{40'h1010, 3'd4, 1'b1, 1'b1, 4'h1, 1'b0, 0, 16};
        vt[1] = '{40'h1003, 3'd0, 1'b1, 1'b1, 4'h0, 1'b0, 3, 1};
        vt[2] = '{40'h1006, 3'd2, 1'b0, 1'b1, 4'h0, 1'b0, 4, 4};
        vt[3] = '{40'h1100, 3'd0, 1'b1, 1'b0, 4'h0, 1'b1, 0, 0};
        vt[4] = '{40'h1020, 3'd5, 1'b1, 1'b0, 4'h2, 1'b1, 0, 0};
        vt[5] = '{40'h0FFF, 3'd0, 1'b0, 1'b0, 4'hF, 1'b1, 0, 0};
        vt[6] = '{40'h10F8, 3'd3, 1'b0, 1'b1, 4'hF, 1'b0, 8, 8};
        vt[7] = '{40'h10FF, 3'd0, 1'b1, 1'b1, 4'hF, 1'b0, 15, 1};

        rst_n = 1'b0;
        clr   = 1'b0;
        drive('0, 3'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rslverr", rslverr, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_ce", ce, 0);
        chk("rst_beats", beats, 0);
        chk("rst_bursts", bursts, 0);
        chk("rst_errs", errs, 0);

        for (int i = 0; i < 8; i++) begin
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
            drive(vt[i].addr, vt[i].size, vt[i].last, 1'b1);
            #1;
            chk($sformatf("v%0d_mem_ce", i), ce, vt[i].ce);
            chk($sformatf("v%0d_mem_addr", i), maddr, vt[i].maddr);
            @(negedge clk);
            drive('0, 3'd0, 1'b0, 1'b0);
            chk($sformatf("v%0d_early_rvalid", i), rvalid, 0);
            @(negedge clk);
            chk($sformatf("v%0d_rvalid", i), rvalid, 1);
            chk($sformatf("v%0d_rslverr", i), rslverr, vt[i].err);
            chk($sformatf("v%0d_rdata", i), rdata, vt[i].err ? '0 : exp_data(vt[i].maddr, vt[i].lo, vt[i].n));
            @(negedge clk);
            chk($sformatf("v%0d_beats", i), beats, 1);
            chk($sformatf("v%0d_bursts", i), bursts, vt[i].last);
            chk($sformatf("v%0d_errs", i), errs, vt[i].err);
        end

        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        for (int t = 0; t < 8; t++) begin
            if (t >= 2 && t <= 5) begin
                chk($sformatf("burst_rvalid%0d", t - 2), rvalid, 1);
                chk($sformatf("burst_rdata%0d", t - 2), rdata, mem[t - 2]);
            end else chk($sformatf("burst_idle%0d", t), rvalid, 0);
            if (t == 4) chk("burst_beats_mid", beats, 2);
            if (t == 5) chk("burst_bursts_pre", bursts, 0);
            if (t == 6) begin
                chk("burst_bursts_post", bursts, 1);
                chk("burst_beats_sat", beats, 3);
            end
            if (t < 4) drive(40'h1000 + 40'(t * 16), 3'd4, t == 3, 1'b1);
            else drive('0, 3'd0, 1'b0, 1'b0);
            @(negedge clk);
        end

        drive(40'h1000, 3'd4, 1'b1, 1'b1);
        @(negedge clk);
        drive('0, 3'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("sat_beats5", beats, 3);
        chk("sat_bursts", bursts, 2);

        drive(40'h1010, 3'd4, 1'b0, 1'b1);
        @(negedge clk);
        drive('0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("clr_rvalid", rvalid, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_beats", beats, 0);
        chk("clr_bursts", bursts, 0);

        drive(40'h1020, 3'd4, 1'b1, 1'b1);
        @(negedge clk);
        drive('0, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_rvalid", rvalid, 0);
        chk("midrst_rslverr", rslverr, 0);
        chk("midrst_rdata", rdata, 0);
        chk("midrst_mem_ce", ce, 0);
        @(negedge clk);
        chk("midrst_rvalid_late", rvalid, 0);
        chk("midrst_beats", beats, 0);
        chk("midrst_bursts", bursts, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
